// File: rtl/mesh_term_src_fifo.sv
// Per-terminal ingress FIFO feeding one mesh terminal input with first-word fall-through,
// sticky overflow/underflow flags and a saturating drop counter.
module mesh_term_src_fifo #(
  parameter int unsigned PCKG_SZ = 40,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [PCKG_SZ-1:0]         data_in,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       pndng_i_in,
  output logic [PCKG_SZ-1:0]         data_out_i_in,
  input  logic                       popin,
  output logic                       overflow,
  output logic                       underflow,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [PCKG_SZ-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic empty;
  logic is_full;
  logic pop_ok;
  logic push_ok;
  logic push_drop;

  assign empty   = (count_q == '0);
  assign is_full = (count_q == FullCnt);

  always_comb begin
    pop_ok      = 1'b0;
    push_ok     = 1'b0;
    push_drop   = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    drop_cnt_d  = drop_cnt_q;

    pop_ok = popin && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    if (push) begin
      if (!is_full || pop_ok) begin
        push_ok = 1'b1;
      end else begin
        push_drop = 1'b1;
      end
    end

    if (popin && empty) begin
      underflow_d = 1'b1;
    end

    if (push_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end

    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage is left uncleared by reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign full          = is_full;
  assign count         = count_q;
  assign pndng_i_in    = !empty;
  assign data_out_i_in = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: doc/mesh_term_src_fifo.md
# mesh_term_src_fifo

Per-terminal ingress buffer feeding one terminal input of the mesh router network. The test agent or traffic source pushes packets into it. The block then presents the head packet to the mesh through the `pndng_i_in` / `data_out_i_in` / `popin` handshake that the mesh generator expects on each terminal. The block also detects protocol and capacity errors.

## Interface
Parameters:
- `PCKG_SZ`, default 40: packet width in bits, carried unmodified.
- `DEPTH`, default 16: number of packet entries; minimum 2; need not be a power of two.
- `CNT_W`, default 8: width of the drop counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `push` in 1: source writes `data_in` this cycle.
- `data_in` in `PCKG_SZ`: packet from the source.
- `full` out 1: high when count == `DEPTH`.
- `count` out `$clog2(DEPTH+1)`: entries currently held.
- `pndng_i_in` out 1: head packet valid toward the mesh; high when count > 0.
- `data_out_i_in` out `PCKG_SZ`: head packet; all zeros when empty.
- `popin` in 1: mesh consumes the head packet this cycle.
- `overflow` out 1: sticky; set by a dropped push.
- `underflow` out 1: sticky; set by `popin` while empty.
- `drop_cnt` out `CNT_W`: number of dropped pushes; saturates at all-ones.

## Operation
- Circular storage of `DEPTH` entries with write pointer `wr_ptr` and read pointer `rd_ptr`, plus an explicit occupancy counter.
- Pointers wrap from `DEPTH-1` to 0 by explicit compare, not by modulo-2^n.
- First-word fall-through:
  - `data_out_i_in` is `mem[rd_ptr]` when count > 0, else 0.
  - Driven from registered state only; no combinational path from `push`, `data_in` or `popin` to any output.
- Pop is accepted when `popin`=1 and count > 0. It advances `rd_ptr` and decrements count.
- `popin`=1 with count == 0:
  - Ignored: no pointer or count change.
  - `underflow` set.
- Push is accepted when `push`=1 and one of the following holds:
  - count < `DEPTH`; or
  - count == `DEPTH` and an accepted pop occurs in the same cycle.
- An accepted push writes `mem[wr_ptr]`, advances `wr_ptr` and increments count.
- Push not accepted (full, no pop):
  - Packet discarded; storage unchanged.
  - `overflow` set.
  - `drop_cnt` += 1, holding at 2^`CNT_W`-1.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Push on empty with `popin`=1 in the same cycle:
  - Push accepted; count becomes 1.
  - The pop is an underflow, so `underflow` is set.
- Packets leave in exact push order. Contents are never altered.
- `overflow` and `underflow` stay set until reset.
- Reset (`reset`=0 at a rising edge):
  - Pointers and count go to 0; `overflow`, `underflow` and `drop_cnt` go to 0.
  - `pndng_i_in`=0, `data_out_i_in`=0, `full`=0.
  - Storage contents need not be cleared.
  - Reset wins over `push`/`popin` in the same cycle, including mid-stream; all held packets are lost.

## Timing
- Push at edge N into an empty FIFO: `pndng_i_in`=1 and `data_out_i_in`=`data_in` from edge N until the next state change. Write-to-visible latency is one cycle.
- Pop at edge N: the next entry, or 0 if the FIFO is now empty, appears on `data_out_i_in` after edge N. `pndng_i_in` falls after edge N if count reaches 0.
- Back-to-back pops every cycle are supported. Throughput is one packet per clock in each direction.
- `full`, `count`, flags and `drop_cnt` all update on the same edge as the event that changes them.
- The mesh samples `pndng_i_in`/`data_out_i_in` and drives `popin` in the same cycle. The block depends on `popin` only at the clock edge.

## Test plan
- Reset, then push packets 0x0A_0000_0001, 0x0A_0000_0002, 0x0A_0000_0003 on consecutive cycles, with no popin.
  - After the third edge: count=3, `pndng_i_in`=1, `data_out_i_in`=0x0A_0000_0001.
  - Three popins then return 1, 2, 3 in order; `pndng_i_in`=0 and `data_out_i_in`=0 afterwards.
- Fill to 16 entries (`full`=1), then push 0xFF_FFFF_FFFF.
  - `overflow`=1, `drop_cnt`=1, count stays 16.
  - Draining returns the original 16 packets only.
- With `full`=1, push 0x11 together with popin.
  - Count stays 16, no drop.
  - 0x11 emerges last after the 16th pop.
- Empty FIFO: popin=1 alone sets `underflow`, count=0.
  - Then push 0x22 with popin=1 in the same cycle: count=1, `data_out_i_in`=0x22.
- Push/pop 40 packets with random 0/1 patterns on each side, covering pointer wrap at 15→0 at least twice.
  - Scoreboard order matches exactly; count never exceeds 16 or goes negative.
- Hold 5 entries plus set flags, assert `reset`=0 for one cycle with push=1.
  - Count=0, all outputs 0, the pushed packet is not stored.
